// File: rtl/stream_check_pkg.sv
// Shared types and constants for the stream checking sink and its ready throttle.
package stream_check_pkg;

  typedef enum logic [1:0] {
    READY_ALWAYS = 2'd0,
    READY_NEVER  = 2'd1,
    READY_LFSR   = 2'd2,
    READY_DUTY   = 2'd3
  } ready_mode_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [15:0] LFSR_POLY         = 16'hB400;
  localparam logic [15:0] LFSR_DEFAULT_SEED = 16'hACE1;

  // One step of the right-shifting Galois LFSR.
  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return {1'b0, s[15:1]} ^ (s[0] ? LFSR_POLY : 16'h0000);
  endfunction

endpackage

// File: rtl/stream_check_sink_ready_throttle.sv
// Backpressure pattern generator: produces the next value of the sink's registered ready.
module ready_throttle
  import stream_check_pkg::*;
(
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic        i_enable,
  input  logic        i_load,
  input  ready_mode_e i_mode,
  input  logic [7:0]  i_on,
  input  logic [7:0]  i_off,
  input  logic [15:0] i_seed,
  output logic        o_ready_next
);

  logic [15:0] lfsr_q, lfsr_d, lfsr_cur;
  logic [8:0]  duty_q, duty_d, duty_cur, period;
  logic [7:0]  on_eff;
  logic        duty_ready;

  // A load presents the freshly seeded state so the start edge already uses the new pattern.
  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    lfsr_d     = lfsr_q;
    duty_d     = duty_q;
    on_eff     = (i_on == 8'd0) ? 8'd1 : i_on;
    period     = {1'b0, on_eff} + {1'b0, i_off};
    lfsr_cur   = i_load ? ((i_seed == 16'h0000) ? LFSR_DEFAULT_SEED : i_seed) : lfsr_q;
    duty_cur   = i_load ? 9'd0 : duty_q;
    duty_ready = (i_off == 8'd0) || (duty_cur < {1'b0, on_eff});

    if (i_load || i_enable) begin
      lfsr_d = lfsr_step(lfsr_cur);
      duty_d = (duty_cur + 9'd1 >= period) ? 9'd0 : duty_cur + 9'd1;
    end

    case (i_mode)
      READY_ALWAYS: o_ready_next = 1'b1;
      READY_NEVER:  o_ready_next = 1'b0;
      READY_LFSR:   o_ready_next = lfsr_cur[0];
      READY_DUTY:   o_ready_next = duty_ready;
      default:      o_ready_next = 1'b0;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      lfsr_q <= LFSR_DEFAULT_SEED;
      duty_q <= 9'd0;
    end else begin
      lfsr_q <= lfsr_d;
      duty_q <= duty_d;
    end
  end

endmodule

// File: rtl/stream_check_sink.sv
// Valid/ready stream consumer that throttles ready, checks an arithmetic data sequence,
// counts beats and mismatches, and flags upstream handshake violations.
module stream_check_sink
  import stream_check_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int CNT_WIDTH = 32
) (
  input  logic                 i_clock,
  input  logic                 i_reset,
  input  logic [WIDTH-1:0]     i_in_data,
  input  logic                 i_in_valid,
  output logic                 o_in_ready,
  input  logic                 i_start,
  input  logic [WIDTH-1:0]     i_start_value,
  input  logic [WIDTH-1:0]     i_increment,
  input  logic [CNT_WIDTH-1:0] i_expected_count,
  input  logic [1:0]           i_ready_mode,
  input  logic [7:0]           i_ready_on,
  input  logic [7:0]           i_ready_off,
  input  logic [15:0]          i_lfsr_seed,
  output logic [CNT_WIDTH-1:0] o_beat_count,
  output logic [CNT_WIDTH-1:0] o_err_count,
  output logic                 o_first_err_valid,
  output logic [WIDTH-1:0]     o_first_err_data,
  output logic [WIDTH-1:0]     o_first_err_expected,
  output logic                 o_protocol_err,
  output logic                 o_done,
  output logic                 o_pass
);

  state_e               state_q, state_d;
  logic                 ready_q, ready_d;
  logic [WIDTH-1:0]     expected_q, expected_d;
  logic [CNT_WIDTH-1:0] beat_q, beat_d, err_q, err_d;
  logic                 ferr_valid_q, ferr_valid_d;
  logic [WIDTH-1:0]     ferr_data_q, ferr_data_d, ferr_exp_q, ferr_exp_d;
  logic                 proto_q, proto_d;
  logic                 stall_q, stall_d;
  logic [WIDTH-1:0]     stall_data_q, stall_data_d;
  logic                 thr_ready, accept, final_beat;

  ready_throttle u_throttle (
    .i_clock      (i_clock),
    .i_reset      (i_reset),
    .i_enable     ((state_q == RUN) && !i_start),
    .i_load       (i_start),
    .i_mode       (ready_mode_e'(i_ready_mode)),
    .i_on         (i_ready_on),
    .i_off        (i_ready_off),
    .i_seed       (i_lfsr_seed),
    .o_ready_next (thr_ready)
  );

  always_comb begin
    state_d      = state_q;
    ready_d      = 1'b0;
    expected_d   = expected_q;
    beat_d       = beat_q;
    err_d        = err_q;
    ferr_valid_d = ferr_valid_q;
    ferr_data_d  = ferr_data_q;
    ferr_exp_d   = ferr_exp_q;
    proto_d      = proto_q;
    stall_d      = 1'b0;
    stall_data_d = stall_data_q;

    accept     = (state_q == RUN) && ready_q && i_in_valid && !i_start;
    final_beat = accept && (i_expected_count != '0) &&
                 (beat_q == i_expected_count - CNT_WIDTH'(1));

    if (i_start) begin
      state_d      = RUN;
      ready_d      = thr_ready;
      expected_d   = i_start_value;
      beat_d       = '0;
      err_d        = '0;
      ferr_valid_d = 1'b0;
      ferr_data_d  = '0;
      ferr_exp_d   = '0;
      proto_d      = 1'b0;
    end else if (state_q == RUN) begin
      // Drop ready on the edge that takes the final beat so nothing extra slips in.
      ready_d = final_beat ? 1'b0 : thr_ready;
      if (stall_q && (!i_in_valid || (i_in_data != stall_data_q))) proto_d = 1'b1;
      stall_d      = i_in_valid && !ready_q;
      stall_data_d = i_in_data;

      if (accept) begin
        if (i_in_data != expected_q) begin
          if (err_q != '1) err_d = err_q + CNT_WIDTH'(1);
          if (!ferr_valid_q) begin
            ferr_valid_d = 1'b1;
            ferr_data_d  = i_in_data;
            ferr_exp_d   = expected_q;
          end
        end
        expected_d = expected_q + i_increment;
        if (beat_q != '1) beat_d = beat_q + CNT_WIDTH'(1);
        if (final_beat) state_d = DONE;
      end
    end
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state_q      <= IDLE;
      ready_q      <= 1'b0;
      expected_q   <= '0;
      beat_q       <= '0;
      err_q        <= '0;
      ferr_valid_q <= 1'b0;
      ferr_data_q  <= '0;
      ferr_exp_q   <= '0;
      proto_q      <= 1'b0;
      stall_q      <= 1'b0;
      stall_data_q <= '0;
    end else begin
      state_q      <= state_d;
      ready_q      <= ready_d;
      expected_q   <= expected_d;
      beat_q       <= beat_d;
      err_q        <= err_d;
      ferr_valid_q <= ferr_valid_d;
      ferr_data_q  <= ferr_data_d;
      ferr_exp_q   <= ferr_exp_d;
      proto_q      <= proto_d;
      stall_q      <= stall_d;
      stall_data_q <= stall_data_d;
    end
  end

  assign o_in_ready           = ready_q;
  assign o_beat_count         = beat_q;
  assign o_err_count          = err_q;
  assign o_first_err_valid    = ferr_valid_q;
  assign o_first_err_data     = ferr_data_q;
  assign o_first_err_expected = ferr_exp_q;
  assign o_protocol_err       = proto_q;
  assign o_done               = (state_q == DONE);
  assign o_pass               = (state_q == DONE) && !ferr_valid_q && !proto_q &&
                                (beat_q == i_expected_count);

endmodule

// File: tb/tb_stream_check_sink.sv
// Self-checking bench: randomized upstream source against a sequence/pattern reference model.
module tb_stream_check_sink;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        start = 1'b0;
  logic [15:0] start_value = '0, increment = '0;
  logic [31:0] expected_count = '0;
  logic [1:0]  ready_mode = '0;
  logic [7:0]  ready_on = '0, ready_off = '0;
  logic [15:0] lfsr_seed = '0;
  logic [31:0] beat_count, err_count;
  logic        first_err_valid, protocol_err, done, pass;
  logic [15:0] first_err_data, first_err_expected;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  stream_check_sink #(.WIDTH(16), .CNT_WIDTH(32)) dut (
    .i_clock              (clk),
    .i_reset              (rst_n),
    .i_in_data            (in_data),
    .i_in_valid           (in_valid),
    .o_in_ready           (in_ready),
    .i_start              (start),
    .i_start_value        (start_value),
    .i_increment          (increment),
    .i_expected_count     (expected_count),
    .i_ready_mode         (ready_mode),
    .i_ready_on           (ready_on),
    .i_ready_off          (ready_off),
    .i_lfsr_seed          (lfsr_seed),
    .o_beat_count         (beat_count),
    .o_err_count          (err_count),
    .o_first_err_valid    (first_err_valid),
    .o_first_err_data     (first_err_data),
    .o_first_err_expected (first_err_expected),
    .o_protocol_err       (protocol_err),
    .o_done               (done),
    .o_pass               (pass)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    else n_pass++;
  endtask

  function automatic logic [15:0] ref_lfsr_next(input logic [15:0] s);
    return s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
  endfunction

  task automatic pulse_start(input logic [15:0] sv, input logic [15:0] inc, input int cnt,
                             input int mode, input int on, input int off, input logic [15:0] seed);
    @(negedge clk);
    start_value    = sv;
    increment      = inc;
    expected_count = 32'(cnt);
    ready_mode     = 2'(mode);
    ready_on       = 8'(on);
    ready_off      = 8'(off);
    lfsr_seed      = seed;
    in_valid       = 1'b0;
    start          = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Drives one run and compares ready every cycle plus the final status against the model.
  task automatic run_case(input string name, input logic [15:0] sv, input logic [15:0] inc,
                          input int cnt, input int mode, input int on, input int off,
                          input logic [15:0] seed, input int inj_idx, input logic [15:0] inj_val,
                          input int vpct, input int max_cyc);
    int          beats = 0, errs = 0, on_e, period;
    bit          first = 0, stall = 0, r_exp;
    logic [15:0] fd = '0, fe = '0, lfsr_m, exp_v;

    pulse_start(sv, inc, cnt, mode, on, off, seed);
    check({name, "_start_beats"}, beat_count, 0);
    check({name, "_start_done"}, done, 0);

    lfsr_m = (seed == 16'h0) ? 16'hACE1 : seed;
    on_e   = (on == 0) ? 1 : on;
    period = on_e + off;

    for (int k = 1; k <= max_cyc; k++) begin
      if (cnt != 0 && beats == cnt) break;
      case (mode)
        0:       r_exp = 1'b1;
        1:       r_exp = 1'b0;
        2:       r_exp = lfsr_m[0];
        default: r_exp = (off == 0) || (((k - 1) % period) < on_e);
      endcase
      lfsr_m = ref_lfsr_next(lfsr_m);
      check({name, "_ready"}, in_ready, r_exp);

      if (!stall) begin
        in_valid = ($urandom_range(99) < vpct);
        in_data  = (beats == inj_idx) ? inj_val : sv + 16'(int'(inc) * beats);
      end
      stall = in_valid && !in_ready;
      if (in_valid && in_ready) begin
        exp_v = sv + 16'(int'(inc) * beats);
        if (in_data != exp_v) begin
          errs++;
          if (!first) begin first = 1; fd = in_data; fe = exp_v; end
        end
        beats++;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;

    if (cnt != 0) check({name, "_completed"}, beats, cnt);
    check({name, "_beat_count"}, beat_count, beats);
    check({name, "_err_count"}, err_count, errs);
    check({name, "_first_err_valid"}, first_err_valid, first);
    check({name, "_first_err_data"}, first_err_data, fd);
    check({name, "_first_err_expected"}, first_err_expected, fe);
    check({name, "_protocol_err"}, protocol_err, 0);
    check({name, "_done"}, done, (cnt != 0 && beats == cnt));
    check({name, "_pass"}, pass, (cnt != 0 && beats == cnt && errs == 0));
    if (cnt != 0 && beats == cnt) check({name, "_ready_after_done"}, in_ready, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit found;

    // Reset state, then no start with valid held high.
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_ready", in_ready, 0);
    check("rst_beats", beat_count, 0);
    check("rst_errs", err_count, 0);
    check("rst_flags", {first_err_valid, protocol_err, done, pass}, 0);
    check("rst_ferr", {first_err_data, first_err_expected}, 0);
    in_valid = 1'b1;
    in_data  = 16'h1234;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (i % 25 == 24) check("idle_ready", in_ready, 0);
    end
    check("idle_beats", beat_count, 0);
    check("idle_done", done, 0);
    in_valid = 1'b0;

    run_case("count10", 16'h0000, 16'd2, 10, 0, 0, 0, 16'h0, -1, 16'h0, 100, 100);
    in_valid = 1'b1;
    in_data  = 16'd20;
    repeat (5) begin
      @(negedge clk);
      check("post_done_ready", in_ready, 0);
    end
    check("post_done_beats", beat_count, 10);
    check("post_done_pass", pass, 1);
    in_valid = 1'b0;

    run_case("duty23", 16'h0005, 16'd3, 16, 3, 2, 3, 16'h0, -1, 16'h0, 100, 200);
    run_case("inject", 16'h0000, 16'd3, 8, 0, 0, 0, 16'h0, 4, 16'd7, 100, 100);
    check("inject_first_data", first_err_data, 16'd7);
    check("inject_first_expected", first_err_expected, 16'd12);
    run_case("wrap", 16'hFFFE, 16'd1, 4, 0, 0, 0, 16'h0, -1, 16'h0, 100, 100);
    run_case("lfsr0", 16'h0100, 16'd5, 20, 2, 0, 0, 16'h0, -1, 16'h0, 70, 2000);

    for (int r = 0; r < 4; r++) begin
      int m;
      m = $urandom_range(2);
      m = (m == 0) ? 0 : m + 1;
      run_case("rand", 16'($urandom), 16'($urandom), 1 + $urandom_range(23), m,
               $urandom_range(4), $urandom_range(4), 16'($urandom), -1, 16'h0,
               50 + $urandom_range(50), 3000);
    end

    // Upstream withdraws valid during a stall.
    pulse_start(16'h0, 16'd1, 0, 2, 0, 0, 16'h0);
    check("proto_clear", protocol_err, 0);
    found = 0;
    for (int i = 0; i < 200 && !found; i++) begin
      if (!in_ready) begin
        in_valid = 1'b1;
        in_data  = 16'hBEEF;
        found    = 1;
      end
      @(negedge clk);
    end
    check("proto_stall_found", found, 1);
    in_valid = 1'b0;
    @(negedge clk);
    check("proto_err_set", protocol_err, 1);

    // Reset mid-run clears everything without waiting for a clock edge.
    pulse_start(16'h0, 16'd1, 0, 0, 0, 0, 16'h0);
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_data = 16'(i);
      @(negedge clk);
    end
    in_valid = 1'b0;
    check("midrun_beats", beat_count, 5);
    #2 rst_n = 1'b0;
    #1;
    check("arst_ready", in_ready, 0);
    check("arst_beats", beat_count, 0);
    check("arst_errs", err_count, 0);
    check("arst_flags", {first_err_valid, protocol_err, done, pass}, 0);
    @(negedge clk);
    rst_n = 1'b1;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/stream_check_sink.md
Name: stream_check_sink

Overview:
- Synthesizable valid/ready stream consumer; the receiving end of the handshake used by skid and other pipeline stages.
- Throttles o_in_ready according to a programmable backpressure pattern.
- Checks that accepted data forms an arithmetic sequence, counts beats and mismatches, and flags upstream protocol violations.
- Sits at the downstream port of a DUT stage, in hardware self-test builds and in benches.

Parameters:
- WIDTH, 16, data width of the checked stream.
- CNT_WIDTH, 32, width of the beat and error counters.

Ports:
- i_clock  in  1  clock.
- i_reset  in  1  asynchronous reset, active-low.
- i_in_data  in  WIDTH  stream data.
- i_in_valid  in  1  stream valid.
- o_in_ready  out  1  stream ready; registered.
- i_start  in  1  one-cycle pulse: clear status and enter RUN.
- i_start_value  in  WIDTH  expected value of the first beat.
- i_increment  in  WIDTH  step between consecutive beats.
- i_expected_count  in  CNT_WIDTH  beats to accept; 0 means run forever.
- i_ready_mode  in  2  0 always, 1 never, 2 LFSR random, 3 duty pattern.
- i_ready_on  in  8  duty-mode high cycles; 0 is treated as 1.
- i_ready_off  in  8  duty-mode low cycles; 0 gives continuous ready.
- i_lfsr_seed  in  16  LFSR seed; 0 is replaced by 16'hACE1.
- o_beat_count  out  CNT_WIDTH  accepted beats; saturates.
- o_err_count  out  CNT_WIDTH  data mismatches; saturates.
- o_first_err_valid  out  1  sticky; set on the first mismatch.
- o_first_err_data  out  WIDTH  received value at the first mismatch.
- o_first_err_expected  out  WIDTH  expected value at the first mismatch.
- o_protocol_err  out  1  sticky upstream handshake violation.
- o_done  out  1  high in DONE.
- o_pass  out  1  o_done & no mismatch & no protocol error & beat_count==expected.

Behaviour:
- Reset (i_reset low, async): state IDLE; every output 0; expected register 0; LFSR loaded with 16'hACE1; duty counter 0.
- Beat accepted iff i_in_valid & o_in_ready at a rising edge.
- States:
  - IDLE: ready 0. i_start -> RUN.
  - RUN: ready follows the throttle pattern. Final accepted beat (beat_count+1 == i_expected_count, expected != 0) -> DONE.
  - DONE: ready 0; outputs held. i_start -> RUN.
- i_start in any state, same edge:
  - clears counters, first-error fields and o_protocol_err;
  - loads expected <= i_start_value;
  - reloads LFSR and duty counter;
  - no beat is accepted on the start edge.
- First ready: o_in_ready is registered, so the earliest possible ready is the cycle after i_start.
- Ready on the final beat: next-state ready is forced 0 on the edge accepting the final beat, so exactly i_expected_count beats are accepted.
- On each accept:
  - if i_in_data != expected, increment err_count; capture the first-error fields if none are captured yet;
  - expected <= expected + i_increment, modulo 2^WIDTH (wrap-around is legal);
  - beat_count increments.
- Counters saturate at all-ones and never wrap.
- Throttle, mode 2: Galois LFSR, polynomial 16'hB400, advances every RUN cycle; ready_next = lfsr[0].
- Throttle, mode 3: ready high for max(on,1) cycles, then low for off cycles, repeating; the pattern starts in the high phase.
- Throttle, modes 0 and 1: ready constant 1 and constant 0.
- i_ready_mode changes mid-RUN take effect on the next cycle; the phase counters are not reset.
- Protocol check in RUN: set o_protocol_err if, in a cycle with valid & !ready, on the following cycle either:
  - valid drops, or
  - i_in_data differs.
- Reset mid-RUN: immediate return to reset values; partial results are lost.

Decomposition:
- Package stream_check_pkg holds:
  - ready_mode_e enum (READY_ALWAYS, READY_NEVER, READY_LFSR, READY_DUTY);
  - state_e enum (IDLE, RUN, DONE);
  - LFSR_POLY = 16'hB400 and LFSR_DEFAULT_SEED = 16'hACE1.
- One sub-module, ready_throttle:
  - contains the LFSR, duty counter and mode mux;
  - takes i_clock, i_reset, enable, load, mode, on, off, seed;
  - outputs ready_next.
- The top level holds the FSM, the checker, the counters and the protocol monitor.

Test Plan:
- Reset, mode 0, no i_start, valid held 1 for 100 cycles -> o_in_ready 0, o_beat_count 0, o_done 0.
- Start value 0, increment 2, expected 10, mode 0, upstream counter source always valid -> 10 beats accepted; o_done and o_pass 1; ready 0 after the 10th beat; an 11th valid is not accepted.
- Duty mode on=2, off=3, expected 16, increment 3 -> ready pattern 1,1,0,0,0 repeating; 16 beats; err_count 0; o_pass 1.
- Inject data 7 at beat 4 where 12 is expected (increment 3) -> err_count 1; first_err_data 7; first_err_expected 12; o_pass 0.
- Start value 16'hFFFE, increment 1, expected 4 -> accepts FFFE, FFFF, 0000, 0001 with no errors.
- Mode 2, seed 0; upstream drops valid during a stall -> o_protocol_err 1. Assert i_reset mid-run -> all outputs 0 asynchronously.
